// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between the UART and a combinational ALU: gathers A, B and opcode bytes,
// runs the ALU for one cycle and hands the captured result to the transmitter.
`timescale 1ns/1ps
module uart_alu_ctrl #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int NB_TIMEOUT    = 16,
  parameter int TIMEOUT_TICKS = 48000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout_err,
  output logic               o_rx_drop
);

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

  logic [2:0]            state;
  logic [NB_TIMEOUT-1:0] tmo_cnt;
  logic                  tmo_hit;

  // A received byte always has priority over an expiring tick, so only idle ticks count.
  assign tmo_hit = i_tick && (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_WAIT_A;
      tmo_cnt       <= '0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_op      <= '0;
      o_tx_data     <= '0;
      o_timeout_err <= 1'b0;
      o_rx_drop     <= 1'b0;
    end else begin
      o_timeout_err <= 1'b0;
      o_rx_drop     <= 1'b0;
      case (state)
        ST_WAIT_A: begin
          tmo_cnt <= '0;
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            tmo_cnt <= '0;
            state   <= ST_WAIT_OP;
          end else if (tmo_hit) begin
            tmo_cnt       <= '0;
            o_timeout_err <= 1'b1;
            state         <= ST_WAIT_A;
          end else if (i_tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            tmo_cnt  <= '0;
            state    <= ST_EXEC;
          end else if (tmo_hit) begin
            tmo_cnt       <= '0;
            o_timeout_err <= 1'b1;
            state         <= ST_WAIT_A;
          end else if (i_tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_EXEC: begin
          tmo_cnt   <= '0;
          o_tx_data <= i_alu_result;
          o_rx_drop <= i_rx_done;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          tmo_cnt   <= '0;
          o_rx_drop <= i_rx_done;
          state     <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          tmo_cnt   <= '0;
          o_rx_drop <= i_rx_done;
          if (i_tx_done) state <= ST_WAIT_A;
        end
        default: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign o_tx_start = (state == ST_SEND);
  assign o_busy     = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: stimulus pushes expected TX results, a negedge
// monitor pops and compares them whenever o_tx_start is presented.
`timescale 1ns/1ps
module tb_uart_alu_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TMO     = 4;

  logic               i_clk = 1'b0;
  logic               i_reset, i_tick, i_rx_done, i_tx_done;
  logic [NB_DATA-1:0] i_rx_data, i_alu_result;
  logic [NB_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start, o_busy, o_timeout_err, o_rx_drop;

  uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TIMEOUT(16), .TIMEOUT_TICKS(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data), .i_tx_done(i_tx_done), .i_alu_result(i_alu_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_timeout_err(o_timeout_err), .o_rx_drop(o_rx_drop)
  );

  always #5 i_clk = ~i_clk;

  // Small ALU standing in for the real one.
  always_comb begin
    i_alu_result = '0;
    case (o_alu_op)
      6'h20: i_alu_result = o_alu_a + o_alu_b;
      6'h22: i_alu_result = o_alu_a - o_alu_b;
      6'h24: i_alu_result = o_alu_a & o_alu_b;
      default: i_alu_result = '0;
    endcase
  end

  typedef struct { logic [7:0] data; logic [5:0] op; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   err_cnt = 0, drop_cnt = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_tx_start) begin
      check("tx_start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=0x%0h required=none", o_tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'd0, o_tx_data}, {24'd0, e.data});
        check("tx_op", {26'd0, o_alu_op}, {26'd0, e.op});
      end
    end
    prev_start = o_tx_start;
    if (o_timeout_err) err_cnt++;
    if (o_rx_drop) drop_cnt++;
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic t);
    i_rx_data = b; i_rx_done = 1'b1; i_tick = t;
    step(1);
    i_rx_done = 1'b0; i_tick = 1'b0;
  endtask

  task automatic pulse_tick();
    i_tick = 1'b1; step(1); i_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
  endtask

  // mode 0: normal handshake, 1: stray byte during WAIT_TX, 2: reset during WAIT_TX
  task automatic finish(input logic [7:0] op_byte, input logic [7:0] exp_data,
                        input logic [5:0] exp_op, input int mode);
    int d0;
    exp_q.push_back('{exp_data, exp_op});
    send_byte(op_byte, 1'b0);
    check("exec_busy", {31'd0, o_busy}, 32'd1);
    check("exec_no_start", {31'd0, o_tx_start}, 32'd0);
    step(1);
    check("send_start", {31'd0, o_tx_start}, 32'd1);
    step(1);
    check("start_one_cycle", {31'd0, o_tx_start}, 32'd0);
    check("alu_op_hold", {26'd0, o_alu_op}, {26'd0, exp_op});
    step(2);
    check("wait_tx_busy", {31'd0, o_busy}, 32'd1);
    if (mode == 1) begin
      d0 = drop_cnt;
      send_byte(8'hAA, 1'b0);
      step(1);
      check("rx_drop", drop_cnt, d0 + 1);
      check("drop_still_busy", {31'd0, o_busy}, 32'd1);
    end
    if (mode == 2) begin
      i_reset = 1'b1;
      step(1);
      i_reset = 1'b0;
      check("reset_in_wait_tx", {2'd0, o_alu_a, o_alu_b, o_alu_op, o_tx_data,
            o_tx_start, o_busy, o_timeout_err, o_rx_drop}, 32'd0);
    end else begin
      pulse_tx_done();
      check("idle_after_tx", {31'd0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    int e0;
    i_reset = 1'b1; i_tick = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = '0;
    step(3);
    check("reset_outputs", {2'd0, o_alu_a, o_alu_b, o_alu_op, o_tx_data,
          o_tx_start, o_busy, o_timeout_err, o_rx_drop}, 32'd0);
    i_reset = 1'b0;
    step(1);

    // 1: basic add
    send_byte(8'h05, 1'b0); step(1); send_byte(8'h03, 1'b0);
    finish(8'h20, 8'h08, 6'h20, 0);

    // 2: timeout after operand A, then a clean frame
    e0 = err_cnt;
    send_byte(8'h05, 1'b0);
    repeat (TMO - 1) begin pulse_tick(); step(1); end
    step(1);
    check("no_early_timeout", err_cnt, e0);
    pulse_tick(); step(1);
    check("timeout_err", err_cnt, e0 + 1);
    check("timeout_idle", {31'd0, o_busy}, 32'd0);
    check("stale_a", {24'd0, o_alu_a}, 32'h05);
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
    finish(8'h20, 8'h02, 6'h20, 0);

    // 3: stray tx_done ignored; byte B coincides with the expiring tick
    e0 = err_cnt;
    send_byte(8'h07, 1'b0);
    pulse_tx_done();
    repeat (TMO - 1) pulse_tick();
    send_byte(8'h02, 1'b1);
    step(1);
    check("no_timeout_on_accept", err_cnt, e0);
    check("b_accepted", {24'd0, o_alu_b}, 32'h02);
    finish(8'h22, 8'h05, 6'h22, 0);

    // 4: dropped byte during WAIT_TX, then another frame
    send_byte(8'h0C, 1'b0); send_byte(8'h0A, 1'b0);
    finish(8'h24, 8'h08, 6'h24, 1);
    send_byte(8'h30, 1'b0); send_byte(8'h12, 1'b0);
    finish(8'h20, 8'h42, 6'h20, 0);

    // 5: reset in WAIT_TX, then a full frame
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    finish(8'h20, 8'h33, 6'h20, 2);
    send_byte(8'h40, 1'b0); send_byte(8'h40, 1'b0);
    finish(8'h20, 8'h80, 6'h20, 0);

    // 6: opcode truncated to low NB_OP bits
    send_byte(8'h10, 1'b0); send_byte(8'h04, 1'b0);
    finish(8'hE2, 8'h0C, 6'h22, 0);

    step(2);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
